mag_sar_search: RTL and testbench

- Successive-approximation search controller; the driving side of the magnitude-comparator interface.
- Generates a trial operand for a 7485-style comparator on the B input and consumes the ALB/AGB/AEB result.
- Binary-searches, MSB first, for the largest trial T such that the comparator reports A >= T.
- Used in the calculator datapath for value recovery, integer square root and quotient-digit search, against any comparator whose result is monotonic in T.

---
 rtl/mag_sar_search_pkg.sv | 20 ++
 rtl/mag_sar_search_if.sv | 27 ++
 rtl/_8bitmagcom.sv | 27 ++
 rtl/mag_sar_search.sv | 134 +++++++++++++
 tb/tb_mag_sar_search.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mag_sar_search_pkg.sv
// rtl/mag_sar_search_pkg.sv - shared types and compare-flag encodings for the SAR search controller
package mag_sar_search_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Compare flags packed as {alb, agb, aeb}
    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    function automatic logic is_onehot(input logic [2:0] flags);
        return (flags == LT) || (flags == GT) || (flags == EQ);
    endfunction

endpackage

// File: rtl/mag_sar_search_if.sv
// rtl/mag_sar_search_if.sv - request/result and comparator-side signals of the SAR search controller
interface mag_sar_search_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             exact;
    logic             error;
    logic [WIDTH-1:0] trial;
    logic             cmp_alb;
    logic             cmp_agb;
    logic             cmp_aeb;

    // Search controller side
    modport master (
        input  start, cmp_alb, cmp_agb, cmp_aeb,
        output busy, done, result, exact, error, trial
    );

    // Requester / comparator side
    modport slave (
        output start, cmp_alb, cmp_agb, cmp_aeb,
        input  busy, done, result, exact, error, trial
    );
endinterface

// File: rtl/_8bitmagcom.sv
// rtl/_8bitmagcom.sv - 8-bit 7485-style magnitude comparator with cascade inputs
module _8bitmagcom (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       alb_in,
    input  logic       agb_in,
    input  logic       aeb_in,
    output logic       alb,
    output logic       agb,
    output logic       aeb
);
    // On equality the cascade inputs decide the result, as in a 7485 chain
    always_comb begin
        alb = 1'b0;
        agb = 1'b0;
        aeb = 1'b0;
        if (a > b) begin
            agb = 1'b1;
        end else if (a < b) begin
            alb = 1'b1;
        end else begin
            alb = alb_in;
            agb = agb_in;
            aeb = aeb_in;
        end
    end
endmodule

// File: rtl/mag_sar_search.sv
// rtl/mag_sar_search.sv - MSB-first successive-approximation search driving a magnitude comparator
module mag_sar_search
    import mag_sar_search_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    mag_sar_search_if.master   bus
);
    localparam int KW = $clog2(WIDTH);
    localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

    state_t           state, state_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [KW-1:0]    k, k_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             exact_q, exact_d;
    logic             error_q, error_d;
    logic [2:0]       flags;
    logic [WIDTH-1:0] acc_kept;

    assign flags    = {bus.cmp_alb, bus.cmp_agb, bus.cmp_aeb};
    assign acc_kept = (flags == GT) ? (acc | (WIDTH'(1) << k)) : acc;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            k        <= '0;
            cnt      <= '0;
            trial_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exact_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_d;
            acc      <= acc_d;
            k        <= k_d;
            cnt      <= cnt_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            exact_q  <= exact_d;
            error_q  <= error_d;
        end
    end

    // Next-state and next-output logic; done/result are set on entry to DONE so they are valid in that cycle
    always_comb begin
        state_d  = state;
        acc_d    = acc;
        k_d      = k;
        cnt_d    = cnt;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        exact_d  = exact_q;
        error_d  = error_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    k_d     = KW'(WIDTH - 1);
                    exact_d = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(CMP_LAT);
                    state_d = (CMP_LAT == 0) ? TRY : WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end
                if (cnt <= CW'(1)) begin
                    state_d = TRY;
                end
            end
            TRY: begin
                if (!is_onehot(flags)) begin
                    error_d  = 1'b1;
                    result_d = acc;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (flags == EQ) begin
                    acc_d    = trial_q;
                    exact_d  = 1'b1;
                    result_d = trial_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    acc_d = acc_kept;
                    if (k == '0) begin
                        result_d = acc_kept;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        k_d     = k - 1'b1;
                        cnt_d   = CW'(CMP_LAT);
                        state_d = (CMP_LAT == 0) ? TRY : WAIT;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        trial_d = ((state_d == TRY) || (state_d == WAIT)) ? (acc_d | (WIDTH'(1) << k_d)) : '0;
    end

    assign bus.trial  = trial_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.exact  = exact_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_mag_sar_search.sv
// tb/tb_mag_sar_search.sv - directed-vector bench for the SAR search controller
module tb_mag_sar_search;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       forcing = 1'b0;
    logic [7:0] a0 = 8'h00;
    logic [7:0] a1 = 8'h00;
    logic       c0_alb, c0_agb, c0_aeb;
    logic       c1_alb, c1_agb, c1_aeb;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] tr [0:63];
    logic [7:0] res;
    logic       ex;
    logic       er;
    int         dc;

    always #5 clk = ~clk;

    mag_sar_search_if #(.WIDTH(8)) i0 ();
    mag_sar_search_if #(.WIDTH(8)) i1 ();

    assign i0.start   = start0;
    assign i1.start   = start1;
    assign i0.cmp_alb = forcing ? 1'b1 : c0_alb;
    assign i0.cmp_agb = forcing ? 1'b1 : c0_agb;
    assign i0.cmp_aeb = forcing ? 1'b0 : c0_aeb;
    assign i1.cmp_alb = c1_alb;
    assign i1.cmp_agb = c1_agb;
    assign i1.cmp_aeb = c1_aeb;

    mag_sar_search #(.WIDTH(8), .CMP_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(i0.master));
    mag_sar_search #(.WIDTH(8), .CMP_LAT(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.master));

    _8bitmagcom u_cmp0 (.a(a0), .b(i0.trial), .alb_in(1'b0), .agb_in(1'b0), .aeb_in(1'b1),
                        .alb(c0_alb), .agb(c0_agb), .aeb(c0_aeb));
    _8bitmagcom u_cmp1 (.a(a1), .b(i1.trial), .alb_in(1'b0), .agb_in(1'b0), .aeb_in(1'b1),
                        .alb(c1_alb), .agb(c1_agb), .aeb(c1_aeb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Start a search on DUT sel with operand a; cycle 0 is the start cycle.
    // start_at pulses start again in that cycle, force_at forces ALB+AGB on DUT0 in that cycle.
    task automatic run(input int sel, input logic [7:0] a, input int start_at,
                       input int force_at, output int done_cyc);
        int cyc;
        done_cyc = -1;
        for (int i = 0; i < 64; i++) tr[i] = 8'h00;
        @(negedge clk);
        if (sel == 0) begin a0 = a; start0 = 1'b1; end
        else          begin a1 = a; start1 = 1'b1; end
        @(negedge clk);
        cyc = 1;
        while (cyc < 60) begin
            if (sel == 0) start0 = (cyc == start_at);
            else          start1 = (cyc == start_at);
            forcing = (cyc == force_at);
            if ((sel == 0 ? i0.done : i1.done) === 1'b1) begin
                done_cyc = cyc;
                res = (sel == 0) ? i0.result : i1.result;
                ex  = (sel == 0) ? i0.exact  : i1.exact;
                er  = (sel == 0) ? i0.error  : i1.error;
                break;
            end
            tr[cyc] = (sel == 0) ? i0.trial : i1.trial;
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        start0  = 1'b0;
        start1  = 1'b0;
        forcing = 1'b0;
    endtask

    logic [7:0] exp5a [0:6];
    logic [7:0] expff [0:7];

    initial begin
        exp5a = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
        expff = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

        repeat (2) @(negedge clk);
        chk("rst_trial",  32'(i0.trial),  32'h0);
        chk("rst_busy",   32'(i0.busy),   32'h0);
        chk("rst_done",   32'(i0.done),   32'h0);
        chk("rst_result", 32'(i0.result), 32'h0);
        chk("rst_exact",  32'(i0.exact),  32'h0);
        chk("rst_error",  32'(i0.error),  32'h0);
        chk("rst_busy1",  32'(i1.busy),   32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // A=0x5A, with a start pulsed during the DONE cycle
        run(0, 8'h5A, 8, 99, dc);
        for (int i = 0; i < 7; i++) chk($sformatf("t5a_trial%0d", i + 1), 32'(tr[i + 1]), 32'(exp5a[i]));
        chk("t5a_done_cyc", 32'(dc), 32'd8);
        chk("t5a_result",   32'(res), 32'h5A);
        chk("t5a_exact",    32'(ex),  32'h1);
        chk("t5a_error",    32'(er),  32'h0);
        chk("t5a_busy_after",  32'(i0.busy),  32'h0);
        chk("t5a_trial_after", 32'(i0.trial), 32'h0);
        @(negedge clk);
        chk("t5a_start_in_done_ignored", 32'(i0.busy), 32'h0);

        // A=0x00: all ALB, full length
        run(0, 8'h00, 99, 99, dc);
        chk("t00_trial1",   32'(tr[1]), 32'h80);
        chk("t00_trial8",   32'(tr[8]), 32'h01);
        chk("t00_done_cyc", 32'(dc),    32'd9);
        chk("t00_result",   32'(res),   32'h00);
        chk("t00_exact",    32'(ex),    32'h0);

        // A=0xFF: AEB on the last trial
        run(0, 8'hFF, 99, 99, dc);
        for (int i = 0; i < 8; i++) chk($sformatf("tff_trial%0d", i + 1), 32'(tr[i + 1]), 32'(expff[i]));
        chk("tff_done_cyc", 32'(dc),  32'd9);
        chk("tff_result",   32'(res), 32'hFF);
        chk("tff_exact",    32'(ex),  32'h1);

        // CMP_LAT=2, A=0x01
        run(1, 8'h01, 99, 99, dc);
        chk("lat_trial1",   32'(tr[1]),  32'h80);
        chk("lat_trial3",   32'(tr[3]),  32'h80);
        chk("lat_trial4",   32'(tr[4]),  32'h40);
        chk("lat_trial24",  32'(tr[24]), 32'h01);
        chk("lat_done_cyc", 32'(dc),     32'd25);
        chk("lat_result",   32'(res),    32'h01);
        chk("lat_exact",    32'(ex),     32'h1);

        // Bad flags on the 3rd sample, with a repeat start while busy
        run(0, 8'h5A, 2, 3, dc);
        chk("err_trial3",   32'(tr[3]), 32'h60);
        chk("err_done_cyc", 32'(dc),    32'd4);
        chk("err_error",    32'(er),    32'h1);
        chk("err_result",   32'(res),   32'h40);
        chk("err_exact",    32'(ex),    32'h0);

        // Reset mid-search at trial 0x60
        @(negedge clk);
        a0 = 8'h5A;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rmid_trial_before", 32'(i0.trial), 32'h60);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_trial",  32'(i0.trial),  32'h0);
        chk("rmid_busy",   32'(i0.busy),   32'h0);
        chk("rmid_result", 32'(i0.result), 32'h0);
        chk("rmid_error",  32'(i0.error),  32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rmid_no_done", 32'(i0.done), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 8'h5A, 99, 99, dc);
        chk("post_rst_done_cyc", 32'(dc),  32'd8);
        chk("post_rst_result",   32'(res), 32'h5A);
        chk("post_rst_exact",    32'(ex),  32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
